gmii_tx_frame_monitor: RTL
==========================

// Module: gmii_tx_frame_monitor
// PURPOSE
//   Passive per-port checker on one switch GMII TX output (gmii_tx_*_o of one port).
//   Parses each frame: preamble/SFD, dst MAC, src MAC, EtherType, payload, FCS.
//   Emits one result record per frame and keeps ok/error frame counters.
//   Multiport benches use it to score flood vs unicast delivery and payload signatures.
// PARAMETERS
//   PREAMBLE_LEN  7     required count of 0x55 bytes before SFD 0xD5
//   MIN_PAYLOAD   46    smallest legal payload length (bytes, FCS excluded)
//   MAX_PAYLOAD   1500  largest legal payload length
//   MIN_IFG       12    minimum idle cycles (tx_en_i=0) required between frames
//   CNT_W         32    width of frame counters
// PORTS
//   gmii_tx_clk_i   in   1      GMII TX clock; all logic on its rising edge
//   gmii_rst_i      in   1      synchronous, active-high reset
//   gmii_tx_data_i  in   8      TX byte
//   gmii_tx_en_i    in   1      TX enable; high for preamble through FCS
//   gmii_tx_er_i    in   1      TX error
//   frm_valid_o     out  1      1-cycle pulse: result fields valid
//   frm_dst_o       out  48     dst MAC, first wire byte = [47:40]
//   frm_src_o       out  48     src MAC, first wire byte = [47:40]
//   frm_type_o      out  16     EtherType, first wire byte = [15:8]
//   frm_sig_o       out  32     first 4 payload bytes, payload byte 0 = [31:24]
//   frm_len_o       out  11     payload length (bytes after EtherType minus 4), saturates at 2047
//   frm_fcs_o       out  32     last 4 bytes; first of the four sent = [7:0]
//   frm_err_o       out  5      {ifg, txer, long, short, preamble}; 0 = good frame
//   frm_ok_cnt_o    out  CNT_W  frames reported with frm_err_o==0, saturating
//   frm_err_cnt_o   out  CNT_W  frames reported with frm_err_o!=0, saturating
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; idle counter preset to MIN_IFG; first frame after reset is never ifg-flagged.
// - Frame = maximal run of cycles with gmii_tx_en_i=1. Frame ends on the first sampled cycle with en=0.
// - States:
//     IDLE:   en=1 & data=0x55 -> PRE, pre_cnt=1
//             en=1 & other byte -> DROP with preamble error
//     PRE:    0x55 -> pre_cnt++
//             0xD5 with pre_cnt==PREAMBLE_LEN -> HDR
//             any other byte or count -> DROP, preamble err
//     HDR:    14 bytes fill dst[6], src[6], type[2] -> BODY
//     BODY:   body_cnt++ (saturating 2047); bytes 0..3 -> sig; every byte shifts a 4-byte FCS window
//     DROP:   consume until en=0, keep error flags
//     Any state with en=0 ends the frame -> REPORT, then IDLE.
// - REPORT: frm_valid_o=1 exactly one cycle, the cycle after the first en=0 sample. All fields registered and held until next report.
//     len  = body_cnt-4; 0 if body_cnt<4
//     short: frame ended in PRE or HDR, or len<MIN_PAYLOAD
//     long:  len>MAX_PAYLOAD
//     txer:  gmii_tx_er_i=1 on any en=1 cycle of the frame
//     ifg:   idle cycles before the frame < MIN_IFG
//   Fields not reached before the frame ended report 0.
// - Idle counter counts en=0 cycles, saturates at MIN_IFG; cleared when en rises.
// - frm_valid_o and the counter increment occur in the same cycle. Counters saturate at all-ones; no wrap.
// - Back-to-back: a new frame may start in the REPORT cycle. It is parsed normally and ifg-flagged.
// - Reset mid-frame clears all state. If en=1 on the first post-reset cycle, the block enters DROP.
//   That frame is discarded silently: no report, no count.
// - Fully passive: no backpressure, no outputs to the switch.
// TESTING
// - 7x55,D5, dst 0A00000000A0, src 020000000010, type 0800, 64 payload bytes, FCS EF BE AD DE, en low
//   -> 1 pulse; len=64, fcs=DEADBEEF, err=0, ok_cnt=1.
// - Same frame with 40-byte payload -> len=40, err=00010. Same frame with 1600-byte payload -> err=00100, err_cnt+1.
// - 6x55 then D5 -> err=00001, remaining fields 0. 8x55 -> err=00001.
// - gmii_tx_er_i high 1 cycle mid-payload -> err=01000. Next frame after 5 idle cycles -> err=10000.
//   After 12 idle cycles -> err=0.
// - Frame ends after 3 dst bytes -> err=00010, dst/src/type/len = 0, exactly one pulse.
// - Assert gmii_rst_i mid-frame, release with en high -> no pulse, counters 0.
//   Next clean frame after 12 idle cycles -> ok_cnt=1.

Source files
------------

// File: rtl/gmii_tx_frame_monitor.sv
// gmii_tx_frame_monitor
//   Passive checker for one GMII TX stream. Each frame (a maximal run of
//   gmii_tx_en_i=1) is parsed into preamble/SFD, dst MAC, src MAC,
//   EtherType, payload and FCS. One result record is published per frame,
//   and saturating ok/error frame counters are kept.
//
// Ports
//   gmii_tx_clk_i   clock, rising edge
//   gmii_rst_i      synchronous active-high reset
//   gmii_tx_data_i  TX byte
//   gmii_tx_en_i    TX enable (preamble through FCS)
//   gmii_tx_er_i    TX error
//   frm_valid_o     one-cycle pulse, result fields below are new
//   frm_dst_o       dst MAC, first wire byte in [47:40]
//   frm_src_o       src MAC, first wire byte in [47:40]
//   frm_type_o      EtherType, first wire byte in [15:8]
//   frm_sig_o       first 4 payload bytes, payload byte 0 in [31:24]
//   frm_len_o       payload length (body bytes minus FCS)
//   frm_fcs_o       last 4 bytes, first of them in [7:0]
//   frm_err_o       {ifg, txer, long, short, preamble}
//   frm_ok_cnt_o    frames reported without error (saturating)
//   frm_err_cnt_o   frames reported with error (saturating)
module gmii_tx_frame_monitor #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 46,
    parameter int MAX_PAYLOAD  = 1500,
    parameter int MIN_IFG      = 12,
    parameter int CNT_W        = 32
) (
    input  logic             gmii_tx_clk_i,
    input  logic             gmii_rst_i,
    input  logic [7:0]       gmii_tx_data_i,
    input  logic             gmii_tx_en_i,
    input  logic             gmii_tx_er_i,
    output logic             frm_valid_o,
    output logic [47:0]      frm_dst_o,
    output logic [47:0]      frm_src_o,
    output logic [15:0]      frm_type_o,
    output logic [31:0]      frm_sig_o,
    output logic [10:0]      frm_len_o,
    output logic [31:0]      frm_fcs_o,
    output logic [4:0]       frm_err_o,
    output logic [CNT_W-1:0] frm_ok_cnt_o,
    output logic [CNT_W-1:0] frm_err_cnt_o
);
    // Counter widths leave headroom so a saturated value never equals the target.
    localparam int PRE_W  = $clog2(PREAMBLE_LEN + 2);
    localparam int IDLE_W = $clog2(MIN_IFG + 2);
    localparam logic [PRE_W-1:0]  PRE_LEN_L = PRE_W'(PREAMBLE_LEN);
    localparam logic [IDLE_W-1:0] IFG_L     = IDLE_W'(MIN_IFG);
    localparam logic [10:0]       MIN_PAY_L = 11'(MIN_PAYLOAD);
    localparam logic [10:0]       MAX_PAY_L = 11'(MAX_PAYLOAD);
    localparam logic [7:0]        PRE_BYTE  = 8'h55;
    localparam logic [7:0]        SFD_BYTE  = 8'hD5;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_BODY, S_DROP} state_t;

    state_t              state_q, state_d;
    logic                post_rst_q;
    logic                silent_q, silent_d;
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [3:0]          hdr_cnt_q, hdr_cnt_d;
    logic [10:0]         body_cnt_q, body_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [47:0]         dst_q, dst_d, src_q, src_d;
    logic [15:0]         type_q, type_d;
    logic [31:0]         sig_q, sig_d, fcs_q, fcs_d;
    logic                err_pre_q, err_pre_d, err_txer_q, err_txer_d, err_ifg_q, err_ifg_d;

    logic                out_valid_q;
    logic [47:0]         out_dst_q, out_src_q;
    logic [15:0]         out_type_q;
    logic [31:0]         out_sig_q, out_fcs_q;
    logic [10:0]         out_len_q;
    logic [4:0]          out_err_q;
    logic [CNT_W-1:0]    ok_cnt_q, err_cnt_q;

    logic                report;
    logic [10:0]         res_len;
    logic                res_short, res_long;
    logic [4:0]          res_err;
    logic [47:0]         res_dst, res_src;
    logic [15:0]         res_type;

    // State and datapath registers
    always_ff @(posedge gmii_tx_clk_i) begin
        if (gmii_rst_i) begin
            state_q     <= S_IDLE;
            post_rst_q  <= 1'b1;
            silent_q    <= 1'b0;
            pre_cnt_q   <= '0;
            hdr_cnt_q   <= '0;
            body_cnt_q  <= '0;
            idle_cnt_q  <= IFG_L;
            dst_q       <= '0;
            src_q       <= '0;
            type_q      <= '0;
            sig_q       <= '0;
            fcs_q       <= '0;
            err_pre_q   <= 1'b0;
            err_txer_q  <= 1'b0;
            err_ifg_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_dst_q   <= '0;
            out_src_q   <= '0;
            out_type_q  <= '0;
            out_sig_q   <= '0;
            out_fcs_q   <= '0;
            out_len_q   <= '0;
            out_err_q   <= '0;
            ok_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            post_rst_q  <= 1'b0;
            silent_q    <= silent_d;
            pre_cnt_q   <= pre_cnt_d;
            hdr_cnt_q   <= hdr_cnt_d;
            body_cnt_q  <= body_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            type_q      <= type_d;
            sig_q       <= sig_d;
            fcs_q       <= fcs_d;
            err_pre_q   <= err_pre_d;
            err_txer_q  <= err_txer_d;
            err_ifg_q   <= err_ifg_d;
            out_valid_q <= report;
            if (report) begin
                out_dst_q  <= res_dst;
                out_src_q  <= res_src;
                out_type_q <= res_type;
                out_sig_q  <= sig_q;
                out_fcs_q  <= fcs_q;
                out_len_q  <= res_len;
                out_err_q  <= res_err;
                if (res_err == 5'd0) begin
                    if (ok_cnt_q != '1) ok_cnt_q <= ok_cnt_q + CNT_W'(1);
                end else begin
                    if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        silent_d   = silent_q;
        pre_cnt_d  = pre_cnt_q;
        hdr_cnt_d  = hdr_cnt_q;
        body_cnt_d = body_cnt_q;
        dst_d      = dst_q;
        src_d      = src_q;
        type_d     = type_q;
        sig_d      = sig_q;
        fcs_d      = fcs_q;
        err_pre_d  = err_pre_q;
        err_txer_d = err_txer_q;
        err_ifg_d  = err_ifg_q;
        idle_cnt_d = gmii_tx_en_i ? '0 :
                     ((idle_cnt_q == IFG_L) ? idle_cnt_q : idle_cnt_q + 1'b1);

        if (state_q == S_IDLE) begin
            if (gmii_tx_en_i) begin
                // Frame start: clear everything so unreached fields report 0.
                dst_d      = '0;
                src_d      = '0;
                type_d     = '0;
                sig_d      = '0;
                fcs_d      = '0;
                hdr_cnt_d  = '0;
                body_cnt_d = '0;
                pre_cnt_d  = PRE_W'(1);
                err_pre_d  = 1'b0;
                err_txer_d = gmii_tx_er_i;
                err_ifg_d  = (idle_cnt_q < IFG_L);
                // A frame already in flight when reset released is dropped unreported.
                silent_d   = post_rst_q;
                if (post_rst_q) begin
                    state_d = S_DROP;
                end else if (gmii_tx_data_i == PRE_BYTE) begin
                    state_d = S_PRE;
                end else begin
                    state_d   = S_DROP;
                    err_pre_d = 1'b1;
                end
            end
        end else if (!gmii_tx_en_i) begin
            state_d = S_IDLE;
        end else begin
            err_txer_d = err_txer_q | gmii_tx_er_i;
            case (state_q)
                S_PRE: begin
                    if (gmii_tx_data_i == PRE_BYTE) begin
                        if (pre_cnt_q != '1) pre_cnt_d = pre_cnt_q + 1'b1;
                    end else if (gmii_tx_data_i == SFD_BYTE && pre_cnt_q == PRE_LEN_L) begin
                        state_d = S_HDR;
                    end else begin
                        state_d   = S_DROP;
                        err_pre_d = 1'b1;
                    end
                end
                S_HDR: begin
                    if (hdr_cnt_q < 4'd6)       dst_d  = {dst_q[39:0], gmii_tx_data_i};
                    else if (hdr_cnt_q < 4'd12) src_d  = {src_q[39:0], gmii_tx_data_i};
                    else                        type_d = {type_q[7:0], gmii_tx_data_i};
                    hdr_cnt_d = hdr_cnt_q + 4'd1;
                    if (hdr_cnt_q == 4'd13) state_d = S_BODY;
                end
                S_BODY: begin
                    case (body_cnt_q)
                        11'd0:   sig_d[31:24] = gmii_tx_data_i;
                        11'd1:   sig_d[23:16] = gmii_tx_data_i;
                        11'd2:   sig_d[15:8]  = gmii_tx_data_i;
                        11'd3:   sig_d[7:0]   = gmii_tx_data_i;
                        default: ;
                    endcase
                    // Newest byte enters at the top; oldest of the last four sits in [7:0].
                    fcs_d = {gmii_tx_data_i, fcs_q[31:8]};
                    if (body_cnt_q != 11'h7FF) body_cnt_d = body_cnt_q + 11'd1;
                end
                default: ;
            endcase
        end
    end

    // Result computed during the first en=0 cycle, registered for the pulse
    always_comb begin
        report    = (state_q != S_IDLE) && !gmii_tx_en_i && !silent_q;
        res_len   = (body_cnt_q < 11'd4) ? 11'd0 : body_cnt_q - 11'd4;
        res_short = (state_q == S_PRE) || (state_q == S_HDR) ||
                    ((state_q == S_BODY) && (res_len < MIN_PAY_L));
        res_long  = (state_q == S_BODY) && (res_len > MAX_PAY_L);
        res_err   = {err_ifg_q, err_txer_q, res_long, res_short, err_pre_q};
        res_dst   = (hdr_cnt_q >= 4'd6)  ? dst_q  : 48'd0;
        res_src   = (hdr_cnt_q >= 4'd12) ? src_q  : 48'd0;
        res_type  = (hdr_cnt_q >= 4'd14) ? type_q : 16'd0;
    end

    assign frm_valid_o   = out_valid_q;
    assign frm_dst_o     = out_dst_q;
    assign frm_src_o     = out_src_q;
    assign frm_type_o    = out_type_q;
    assign frm_sig_o     = out_sig_q;
    assign frm_len_o     = out_len_q;
    assign frm_fcs_o     = out_fcs_q;
    assign frm_err_o     = out_err_q;
    assign frm_ok_cnt_o  = ok_cnt_q;
    assign frm_err_cnt_o = err_cnt_q;

endmodule
